// File: rtl/imm_ext_arbiter.sv
// Two-requester immediate extender sharing one datapath.
// Result is registered in a single EMPTY/FULL output stage.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    M_SIGN  = 2'b00,
    M_ZERO  = 2'b01,
    M_UPPER = 2'b10,
    M_RSVD  = 2'b11
  } mode_e;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic        err;
  } res_t;

  function automatic logic [31:0] imm_ext(
    input logic [15:0] imm,
    input logic [1:0]  mode
  );
    logic [31:0] r;
    unique case (mode)
      M_ZERO:  r = {16'h0000, imm};
      M_UPPER: r = {imm, 16'h0000};
      default: r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

endpackage

module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_imm,
  input  logic [1:0]  req0_mode,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_imm,
  input  logic [1:0]  req1_mode,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_id,
  output logic        out_err,
  input  logic        out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  res_t        res_q, res_d;
  logic        last_q, last_d;
  logic        accept;
  logic        gnt1;
  logic        xfer;
  logic [15:0] sel_imm;
  logic [1:0]  sel_mode;

  // last_q resets to 1 so requester 0 wins the first contention
  always_comb begin
    gnt1 = req1_valid & ~req0_valid;
    if (RR && req0_valid && req1_valid) begin
      gnt1 = ~last_q;
    end
  end

  assign accept     = (state_q == EMPTY) | out_ready;
  assign req0_ready = accept & req0_valid & ~gnt1;
  assign req1_ready = accept & req1_valid & gnt1;
  assign xfer       = req0_ready | req1_ready;

  assign sel_imm  = gnt1 ? req1_imm : req0_imm;
  assign sel_mode = gnt1 ? req1_mode : req0_mode;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    last_d  = last_q;
    if (xfer) begin
      res_d.data = imm_ext(sel_imm, sel_mode);
      res_d.id   = gnt1;
      res_d.err  = (sel_mode == M_RSVD);
      last_d     = gnt1;
    end
    unique case (state_q)
      EMPTY: begin
        if (xfer) state_d = FULL;
      end
      FULL: begin
        if (out_ready && !xfer) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      res_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = res_q.data;
  assign out_id    = res_q.id;
  assign out_err   = res_q.err;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: round-robin and fixed-priority
// instances driven in parallel against a transaction-level model.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req1_valid, out_ready;
  logic [15:0] req0_imm, req1_imm;
  logic [1:0]  req0_mode, req1_mode;

  logic        rr_rdy0, rr_rdy1, rr_ov, rr_oid, rr_oerr;
  logic        fp_rdy0, fp_rdy1, fp_ov, fp_oid, fp_oerr;
  logic [31:0] rr_od, fp_od;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imm_ext_arbiter #(.RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_imm(req0_imm),
    .req0_mode(req0_mode), .req0_ready(rr_rdy0),
    .req1_valid(req1_valid), .req1_imm(req1_imm),
    .req1_mode(req1_mode), .req1_ready(rr_rdy1),
    .out_valid(rr_ov), .out_data(rr_od),
    .out_id(rr_oid), .out_err(rr_oerr),
    .out_ready(out_ready)
  );

  imm_ext_arbiter #(.RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_imm(req0_imm),
    .req0_mode(req0_mode), .req0_ready(fp_rdy0),
    .req1_valid(req1_valid), .req1_imm(req1_imm),
    .req1_mode(req1_mode), .req1_ready(fp_rdy1),
    .out_valid(fp_ov), .out_data(fp_od),
    .out_id(fp_oid), .out_err(fp_oerr),
    .out_ready(out_ready)
  );

  // model state, index 0 = round-robin instance, 1 = fixed priority
  bit          m_full[2];
  logic [31:0] m_data[2];
  bit          m_id[2];
  bit          m_err[2];
  bit          m_last[2];

  function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] z;
    z = 32'(imm);
    if (mode == 2'd1) return z;
    if (mode == 2'd2) return z * 32'd65536;
    return imm[15] ? (z + 32'hFFFF0000) : z;
  endfunction

  function automatic bit wins1(input int r);
    if (req0_valid && req1_valid) return (r == 0) && !m_last[r];
    return !req0_valid && req1_valid;
  endfunction

  function automatic bit exp_rdy(input int r, input int n);
    bit can_take;
    bit v;
    can_take = !m_full[r] || out_ready;
    v = (n == 0) ? req0_valid : req1_valid;
    return can_take && v && (wins1(r) == (n == 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int r = 0; r < 2; r++) begin
      if (!rst_n) begin
        m_full[r] <= 1'b0;
        m_data[r] <= 32'h0;
        m_id[r]   <= 1'b0;
        m_err[r]  <= 1'b0;
        m_last[r] <= 1'b1;
      end else if (exp_rdy(r, 0) || exp_rdy(r, 1)) begin
        m_full[r] <= 1'b1;
        m_id[r]   <= wins1(r);
        m_last[r] <= wins1(r);
        m_data[r] <= wins1(r) ? ext(req1_imm, req1_mode) : ext(req0_imm, req0_mode);
        m_err[r]  <= (wins1(r) ? req1_mode : req0_mode) == 2'd3;
      end else if (out_ready) begin
        m_full[r] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int r, input string p,
                          input logic ov, input logic rd0, input logic rd1,
                          input logic [31:0] od, input logic oid, input logic oerr);
    chk({p, ".out_valid"}, 32'(ov), 32'(m_full[r]));
    chk({p, ".req0_ready"}, 32'(rd0), 32'(exp_rdy(r, 0)));
    chk({p, ".req1_ready"}, 32'(rd1), 32'(exp_rdy(r, 1)));
    if (m_full[r] || !rst_n) begin
      chk({p, ".out_data"}, od, m_data[r]);
      chk({p, ".out_id"}, 32'(oid), 32'(m_id[r]));
      chk({p, ".out_err"}, 32'(oerr), 32'(m_err[r]));
    end
  endtask

  always @(negedge clk) begin
    cmp_inst(0, "rr", rr_ov, rr_rdy0, rr_rdy1, rr_od, rr_oid, rr_oerr);
    cmp_inst(1, "fp", fp_ov, fp_rdy0, fp_rdy1, fp_od, fp_oid, fp_oerr);
  end

  task automatic drv(input logic v0, input logic [15:0] i0, input logic [1:0] m0,
                     input logic v1, input logic [15:0] i1, input logic [1:0] m1,
                     input logic ordy);
    req0_valid = v0; req0_imm = i0; req0_mode = m0;
    req1_valid = v1; req1_imm = i1; req1_mode = m1;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {v0, imm0, mode0, v1, imm1, mode1, out_ready}
  logic [38:0] tbl [8] = '{
    {1'b1, 16'h7FFF, 2'd0, 1'b1, 16'h8000, 2'd1, 1'b1},
    {1'b1, 16'h0001, 2'd2, 1'b1, 16'hFFFF, 2'd3, 1'b0},
    {1'b0, 16'h0000, 2'd0, 1'b1, 16'h1357, 2'd2, 1'b1},
    {1'b1, 16'h9ABC, 2'd1, 1'b0, 16'h0000, 2'd0, 1'b1},
    {1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0},
    {1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1},
    {1'b1, 16'h4000, 2'd3, 1'b1, 16'hC000, 2'd0, 1'b0},
    {1'b1, 16'h4000, 2'd3, 1'b1, 16'hC000, 2'd0, 1'b1}
  };

  initial begin
    drv(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 0);
    #2;
    chk("reset.out_valid", 32'(rr_ov), 32'h0);
    chk("reset.out_data", rr_od, 32'h0);
    chk("reset.out_id", 32'(rr_oid), 32'h0);
    chk("reset.out_err", 32'(rr_oerr), 32'h0);
    tick();
    rst_n = 1'b1;

    drv(1, 16'h8001, 2'd0, 0, 16'h0, 2'd0, 1);
    #1 chk("single.rdy0", 32'(rr_rdy0), 32'h1);
    tick();
    chk("single.data", rr_od, 32'hFFFF8001);
    chk("single.id", 32'(rr_oid), 32'h0);
    chk("single.err", 32'(rr_oerr), 32'h0);
    chk("single.valid", 32'(rr_ov), 32'h1);

    drv(1, 16'h8001, 2'd1, 0, 16'h0, 2'd0, 1);
    tick();
    chk("mode01.data", rr_od, 32'h00008001);
    drv(1, 16'h8001, 2'd2, 0, 16'h0, 2'd0, 1);
    tick();
    chk("mode10.data", rr_od, 32'h80010000);
    chk("mode10.err", 32'(rr_oerr), 32'h0);
    drv(1, 16'h8001, 2'd3, 0, 16'h0, 2'd0, 1);
    tick();
    chk("mode11.data", rr_od, 32'hFFFF8001);
    chk("mode11.err", 32'(rr_oerr), 32'h1);

    drv(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 1);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drv(1, 16'h8001, 2'd0, 1, 16'h1234, 2'd1, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr.rdy0", 32'(rr_rdy0), 32'(i % 2 == 0));
      chk("rr.rdy1", 32'(rr_rdy1), 32'(i % 2 == 1));
      chk("fp.rdy0", 32'(fp_rdy0), 32'h1);
      chk("fp.rdy1", 32'(fp_rdy1), 32'h0);
      tick();
      chk("rr.id", 32'(rr_oid), 32'(i % 2));
      chk("rr.valid", 32'(rr_ov), 32'h1);
      chk("fp.id", 32'(fp_oid), 32'h0);
    end

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.rdy0", 32'(rr_rdy0), 32'h0);
      chk("bp.rdy1", 32'(rr_rdy1), 32'h0);
      tick();
      chk("bp.data", rr_od, 32'h00001234);
      chk("bp.id", 32'(rr_oid), 32'h1);
      chk("bp.fp_data", fp_od, 32'hFFFF8001);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_rdy0", 32'(rr_rdy0), 32'h1);
    tick();
    chk("bp.after_data", rr_od, 32'hFFFF8001);
    chk("bp.after_id", 32'(rr_oid), 32'h0);

    rst_n = 1'b0;
    #1;
    chk("rst.rr_valid", 32'(rr_ov), 32'h0);
    chk("rst.fp_valid", 32'(fp_ov), 32'h0);
    chk("rst.rr_data", rr_od, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst.first_rdy0", 32'(rr_rdy0), 32'h1);
    chk("rst.first_rdy1", 32'(rr_rdy1), 32'h0);
    tick();
    chk("rst.first_id", 32'(rr_oid), 32'h0);
    #1 chk("rst.second_rdy1", 32'(rr_rdy1), 32'h1);

    drv(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 1);
    tick();
    drv(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 0);
    tick();
    chk("empty.valid", 32'(rr_ov), 32'h0);
    drv(0, 16'h0, 2'd0, 1, 16'hABCD, 2'd3, 0);
    #1;
    chk("empty.rr_rdy1", 32'(rr_rdy1), 32'h1);
    chk("empty.fp_rdy1", 32'(fp_rdy1), 32'h1);
    tick();
    chk("empty.data", rr_od, 32'hFFFFABCD);
    chk("empty.err", 32'(rr_oerr), 32'h1);
    chk("empty.id", 32'(rr_oid), 32'h1);

    for (int i = 0; i < 8; i++) begin
      drv(tbl[i][38], tbl[i][37:22], tbl[i][21:20],
          tbl[i][19], tbl[i][18:3], tbl[i][2:1], tbl[i][0]);
      tick();
    end

    drv(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 1);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 Parameter: RR, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has an immediate to extend.
REQ-005 req0_imm  input  16  requester 0 immediate field.
REQ-006 req0_mode  input  2  requester 0 extend mode.
REQ-007 req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-008 req1_valid, req1_imm, req1_mode, req1_ready  same widths and directions as the requester 0 ports, for requester 1.
REQ-009 out_valid  output  1  out_data, out_id and out_err hold a result.
REQ-010 out_data  output  32  extended immediate.
REQ-011 out_id  output  1  requester index that produced out_data.
REQ-012 out_err  output  1  result was produced from reserved mode 2'b11.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 The block SHALL share one extend datapath between two requesters and register its result in a single output stage.
REQ-015 Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Accept condition: accept = EMPTY, or FULL with out_ready=1 in the same cycle.
REQ-017 reqN_ready SHALL be combinational and high only when accept=1, reqN_valid=1 and requester N holds the grant; at most one ready is high per cycle.
REQ-018 Grant with RR=1:
- one requester valid: that requester wins;
- both valid: the requester not granted last wins.
REQ-019 Grant with RR=0: requester 0 wins whenever req0_valid=1.
REQ-020 The last-granted pointer SHALL update only on an actual transfer (reqN_valid and reqN_ready both high).
REQ-021 Transfer latency is 1 cycle: data transferred at edge k SHALL appear on out_* with out_valid=1 after edge k.
REQ-022 Mode 2'b00 (sign): out_data = {16 copies of imm[15], imm}.
REQ-023 Mode 2'b01 (zero): out_data = {16'h0000, imm}.
REQ-024 Mode 2'b10 (upper): out_data = {imm, 16'h0000}.
REQ-025 Mode 2'b11 (reserved): out_data SHALL follow the sign rule and out_err=1; in all other modes out_err=0.
REQ-026 FULL with out_ready=0 SHALL hold out_data, out_id and out_err stable and drive both readies low.
REQ-027 FULL with out_ready=1 and a granted valid request SHALL replace the result in the same edge, so out_valid stays 1 (throughput 1 result/cycle).
REQ-028 FULL with out_ready=1 and no valid request SHALL move to EMPTY.
REQ-029 Requester inputs SHALL NOT be sampled unless reqN_ready=1.
REQ-030 out_ready SHALL be ignored while EMPTY.

Reset
REQ-031 While rst_n=0, regardless of clk:
- out_valid=0 and out_data=32'h0;
- out_id=0 and out_err=0;
- last-granted pointer=1, so requester 0 wins the first contention.
REQ-032 Reset asserted mid-transfer SHALL discard the held result.
REQ-033 The first transfer after reset SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-034 Single transfer:
- stimulus: req0 imm=16'h8001, mode=00, out_ready=1;
- response: req0_ready=1, next cycle out_data=32'hFFFF8001, out_id=0, out_err=0.
REQ-035 Mode sweep with imm=16'h8001:
- mode 01 -> 32'h00008001;
- mode 10 -> 32'h80010000;
- mode 11 -> 32'hFFFF8001 with out_err=1.
REQ-036 Round-robin, RR=1:
- stimulus: both valid for 4 cycles, out_ready=1;
- response: grants 0,1,0,1; out_id sequence 0,1,0,1; out_valid continuously 1.
REQ-037 Fixed priority, RR=0:
- stimulus: both valid for 3 cycles;
- response: only req0_ready high; out_id=0 every cycle.
REQ-038 Backpressure:
- stimulus: out_ready=0 for 3 cycles while FULL;
- response: out_* held, both readies 0; on out_ready=1 a pending request transfers in that cycle.
REQ-039 Reset mid-operation:
- stimulus: rst_n pulled low between edges while FULL;
- response: out_valid=0 immediately; after release, requester 0 wins the first contention.
